// File: rtl/uart_rx_engine.sv
// uart_rx_engine: UART receive engine with 2-flop line synchronizer, mid-bit sampling,
// 7/8 data bits, optional parity, and per-frame data/parity/framing results.
module uart_rx_engine #(
   parameter int CNT_W = 19
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx,
   input  logic [CNT_W-1:0] baud_k,
   input  logic             eight,
   input  logic             pen,
   input  logic             ohel,
   output logic [7:0]       rx_data,
   output logic             perr,
   output logic             ferr,
   output logic             rx_done,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;
   state_t           state_q, state_d;
   logic             s1_q, rxs_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_q, bit_d;
   logic [9:0]       sh_q, sh_d;
   logic [7:0]       data_q, data_d;
   logic             perr_q, perr_d, ferr_q, ferr_d, done_q, done_d, busy_q, busy_d;
   logic [3:0]       m;
   logic [9:0]       r;
   logic [7:0]       rdat;
   logic             rpar;
   // m counts the bits shifted after the start bit: data + parity + stop
   assign m    = (eight ? 4'd9 : 4'd8) + {3'd0, pen};
   assign r    = sh_q >> (4'd10 - m);
   assign rdat = eight ? r[7:0] : {1'b0, r[6:0]};
   assign rpar = eight ? r[8] : r[7];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q    <= 1'b1;
         rxs_q   <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         s1_q    <= rx;
         rxs_q   <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      data_d  = data_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (!rxs_q) begin
               state_d = START;
               cnt_d   = baud_k >> 1;
            end
         end
         START: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else if (!rxs_q) begin
               busy_d  = 1'b1;
               cnt_d   = baud_k - 1'b1;
               bit_d   = '0;
               state_d = DATA;
            end else state_d = IDLE;
         end
         DATA: begin
            // reload with baud_k-1 so the sampling period is exactly baud_k clocks
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else begin
               sh_d  = {rxs_q, sh_q[9:1]};
               cnt_d = baud_k - 1'b1;
               bit_d = bit_q + 4'd1;
               if (bit_q == m - 4'd1) state_d = DONE;
            end
         end
         default: begin
            data_d  = rdat;
            perr_d  = pen & ((^rdat ^ rpar) != ohel);
            ferr_d  = ~r[m - 4'd1];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end
   assign rx_data = data_q;
   assign perr    = perr_q;
   assign ferr    = ferr_q;
   assign rx_done = done_q;
   assign busy    = busy_q;
endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: directed frames with a scoreboard queue; a monitor pops and
// compares on every rx_done pulse.
module tb_uart_rx_engine;
   localparam int W = 19;
   logic         clk = 1'b0, reset = 1'b1, rx = 1'b1;
   logic [W-1:0] baud_k = 19'd16;
   logic         eight = 1'b1, pen = 1'b0, ohel = 1'b0;
   logic [7:0]   rx_data;
   logic         perr, ferr, rx_done, busy;

   uart_rx_engine #(.CNT_W(W)) dut (
      .clk(clk), .reset(reset), .rx(rx), .baud_k(baud_k), .eight(eight), .pen(pen),
      .ohel(ohel), .rx_data(rx_data), .perr(perr), .ferr(ferr), .rx_done(rx_done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [7:0] d; logic p; logic f;} exp_t;
   exp_t q[$];
   exp_t e;
   int   total = 0, bad = 0, n_done = 0, base = 0;
   bit   prev_done = 1'b0, busy_seen = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (busy) busy_seen = 1'b1;
      if (prev_done) chk("busy_after_done", {31'd0, busy}, 0);
      prev_done = rx_done;
      if (rx_done) begin
         n_done++;
         if (q.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = q.pop_front();
            chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
            chk("perr", {31'd0, perr}, {31'd0, e.p});
            chk("ferr", {31'd0, ferr}, {31'd0, e.f});
         end
      end
   end

   task automatic bit_t(input logic b);
      rx = b;
      repeat (baud_k) @(posedge clk);
   endtask

   task automatic send(input logic [7:0] d, input int nd, input bit hp, input bit p, input bit s);
      bit_t(1'b0);
      for (int i = 0; i < nd; i++) bit_t(d[i]);
      if (hp) bit_t(p);
      bit_t(s);
      rx = 1'b1;
      repeat (2 * baud_k) @(posedge clk);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_data"}, {24'd0, rx_data}, 0);
      chk({nm, "_perr"}, {31'd0, perr}, 0);
      chk({nm, "_ferr"}, {31'd0, ferr}, 0);
      chk({nm, "_done"}, {31'd0, rx_done}, 0);
      chk({nm, "_busy"}, {31'd0, busy}, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      reset = 1'b1;
      repeat (5) @(posedge clk);
      // 8N1 clean frame
      base = n_done; busy_seen = 1'b0;
      q.push_back('{8'hA5, 1'b0, 1'b0});
      send(8'hA5, 8, 0, 0, 1);
      chk("t1_done_count", n_done - base, 1);
      chk("t1_busy_seen", {31'd0, busy_seen}, 1);
      // 8E1: correct then wrong parity
      pen = 1'b1; ohel = 1'b0;
      q.push_back('{8'h37, 1'b0, 1'b0});
      send(8'h37, 8, 1, 1, 1);
      q.push_back('{8'h37, 1'b1, 1'b0});
      send(8'h37, 8, 1, 0, 1);
      // 7O1: correct then wrong parity
      eight = 1'b0; ohel = 1'b1;
      q.push_back('{8'h7F, 1'b0, 1'b0});
      send(8'h7F, 7, 1, 0, 1);
      q.push_back('{8'h41, 1'b1, 1'b0});
      send(8'h41, 7, 1, 0, 1);
      // short glitch must be rejected as a false start
      base = n_done; busy_seen = 1'b0;
      rx = 1'b0;
      repeat (3) @(posedge clk);
      rx = 1'b1;
      repeat (40) @(posedge clk);
      chk("glitch_done_count", n_done - base, 0);
      chk("glitch_busy_seen", {31'd0, busy_seen}, 0);
      chk("glitch_data_hold", {24'd0, rx_data}, 32'h41);
      // framing error then break
      eight = 1'b1; pen = 1'b0; ohel = 1'b0;
      q.push_back('{8'h55, 1'b0, 1'b1});
      send(8'h55, 8, 0, 0, 0);
      base = n_done;
      repeat (3) q.push_back('{8'h00, 1'b0, 1'b1});
      rx = 1'b0;
      for (int i = 0; i < 2000 && n_done < base + 3; i++) @(posedge clk);
      chk("break_done_count", n_done - base, 3);
      rx = 1'b1; reset = 1'b0;
      repeat (3) @(posedge clk);
      reset = 1'b1;
      repeat (5) @(posedge clk);
      // reset during data bit 4 abandons the frame
      base = n_done;
      bit_t(1'b0);
      for (int i = 0; i < 4; i++) bit_t(1'b1);
      rx = 1'b0;
      repeat (baud_k / 2) @(posedge clk);
      #1 chk("busy_mid_frame", {31'd0, busy}, 1);
      reset = 1'b0; rx = 1'b1;
      #1 chk_zero("mid_reset");
      repeat (3) @(posedge clk);
      reset = 1'b1;
      repeat (5) @(posedge clk);
      q.push_back('{8'hC3, 1'b0, 1'b0});
      send(8'hC3, 8, 0, 0, 1);
      chk("t6_done_count", n_done - base, 1);
      for (int i = 0; i < 1000 && q.size() != 0; i++) @(posedge clk);
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
